// File: rtl/axi_sram_param_ctrl_if.sv
// AXI4-Lite style bus bundle for axi_sram_param_ctrl: AW, W, B, AR and R channels.
interface axi_sram_param_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   axi_awaddr;
  logic                axi_awvalid;
  logic                axi_awready;
  logic [DATA_W-1:0]   axi_wdata;
  logic [DATA_W/8-1:0] axi_wstrb;
  logic                axi_wvalid;
  logic                axi_wready;
  logic [1:0]          axi_bresp;
  logic                axi_bvalid;
  logic                axi_bready;
  logic [ADDR_W-1:0]   axi_araddr;
  logic                axi_arvalid;
  logic                axi_arready;
  logic [DATA_W-1:0]   axi_rdata;
  logic [1:0]          axi_rresp;
  logic                axi_rvalid;
  logic                axi_rready;

  modport master (
    output axi_awaddr, axi_awvalid, input axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid, input axi_wready,
    input axi_bresp, axi_bvalid, output axi_bready,
    output axi_araddr, axi_arvalid, input axi_arready,
    input axi_rdata, axi_rresp, axi_rvalid, output axi_rready
  );

  modport slave (
    input axi_awaddr, axi_awvalid, output axi_awready,
    input axi_wdata, axi_wstrb, axi_wvalid, output axi_wready,
    output axi_bresp, axi_bvalid, input axi_bready,
    input axi_araddr, axi_arvalid, output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid, input axi_rready
  );
endinterface

// File: rtl/axi_sram_param_ctrl.sv
// AXI slave in front of a DEPTH x MEM_W single-port synchronous SRAM.
// AW/W/AR beats are captured into holding registers; a four-state FSM
// serves one write or one read at a time with alternating priority.
module axi_sram_param_ctrl #(
  parameter int DATA_W = 32,
  parameter int MEM_W  = 45,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_sram_param_ctrl_if.slave axi
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int          SHIFT  = $clog2(STRB_W);
  localparam int          IDX_W  = $clog2(DEPTH);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_RESP, RD_ACC, RD_RESP} state_t;
  state_t state_q, state_d;

  logic              aw_held, w_held, ar_held;
  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              last_rd;
  logic              wr_grant, rd_grant;
  logic              aw_hs, w_hs, ar_hs, r_hs;
  logic [ADDR_W-1:0] aw_idx, ar_idx;
  logic              aw_in_range, ar_in_range;
  logic [1:0]        bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;

  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  rd_word;

  assign aw_idx      = aw_addr >> SHIFT;
  assign ar_idx      = ar_addr >> SHIFT;
  assign aw_in_range = aw_idx < ADDR_W'(DEPTH);
  assign ar_in_range = ar_idx < ADDR_W'(DEPTH);

  // Readies are gated by aresetn so they read 0 throughout reset.
  assign axi.axi_awready = aresetn && (state_q == IDLE) && !aw_held;
  assign axi.axi_wready  = aresetn && (state_q == IDLE) && !w_held;
  assign axi.axi_arready = aresetn && (state_q == IDLE) && !ar_held;
  assign axi.axi_bvalid  = (state_q == WR_RESP);
  assign axi.axi_rvalid  = (state_q == RD_RESP);
  assign axi.axi_bresp   = bresp_q;
  assign axi.axi_rresp   = rresp_q;
  assign axi.axi_rdata   = rdata_q;

  assign aw_hs = axi.axi_awvalid && axi.axi_awready;
  assign w_hs  = axi.axi_wvalid  && axi.axi_wready;
  assign ar_hs = axi.axi_arvalid && axi.axi_arready;
  assign r_hs  = axi.axi_rvalid  && axi.axi_rready;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Arbitration and next-state: write wins a tie only if read was served last.
  always_comb begin
    state_d  = state_q;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (aw_held && w_held && (!ar_held || last_rd)) begin
          wr_grant = 1'b1;
          state_d  = WR_RESP;
        end else if (ar_held) begin
          rd_grant = 1'b1;
          state_d  = RD_ACC;
        end
      end
      WR_RESP: if (axi.axi_bready) state_d = IDLE;
      RD_ACC:  state_d = RD_RESP;
      RD_RESP: if (axi.axi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Holding registers for AW/W/AR beats and the last-served class.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      ar_held <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      last_rd <= 1'b1;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= axi.axi_awaddr;
      end else if (wr_grant) begin
        aw_held <= 1'b0;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= axi.axi_wdata;
        w_strb <= axi.axi_wstrb;
      end else if (wr_grant) begin
        w_held <= 1'b0;
      end
      // AR stays held through the read so arready remains low until R completes.
      if (ar_hs) begin
        ar_held <= 1'b1;
        ar_addr <= axi.axi_araddr;
      end else if (r_hs) begin
        ar_held <= 1'b0;
      end
      if (wr_grant) last_rd <= 1'b0;
      if (rd_grant) last_rd <= 1'b1;
    end
  end

  // Response registers: bresp at write grant, rdata/rresp in RD_ACC.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bresp_q <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_grant) bresp_q <= aw_in_range ? OKAY : SLVERR;
      if (state_q == RD_ACC) begin
        rresp_q <= ar_in_range ? OKAY : SLVERR;
        rdata_q <= ar_in_range ? rd_word[DATA_W-1:0] : '0;
      end
    end
  end

  // SRAM port: byte-lane writes on the low DATA_W bits, registered full-word read.
  always_ff @(posedge aclk) begin
    if (wr_grant && aw_in_range) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (w_strb[i]) mem[aw_idx[IDX_W-1:0]][i*8 +: 8] <= w_data[i*8 +: 8];
      end
    end
    if (rd_grant && ar_in_range) rd_word <= mem[ar_idx[IDX_W-1:0]];
  end

  // Bits above DATA_W are carried in the array but not returned on the bus.
  if (MEM_W > DATA_W) begin : g_upper
    logic unused_upper;
    assign unused_upper = ^rd_word[MEM_W-1:DATA_W];
  end

endmodule

// File: tb/tb_axi_sram_param_ctrl.sv
// Testbench for axi_sram_param_ctrl: directed vector table, hand-written
// timing/priority/reset sequences and a randomized run against a word model.
module tb_axi_sram_param_ctrl;
  localparam int DATA_W = 32;
  localparam int MEM_W  = 45;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 32;
  localparam int NREG   = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_sram_param_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  axi_sram_param_ctrl #(.DATA_W(DATA_W), .MEM_W(MEM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .axi(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[14];
  logic [31:0] ref_mem [NREG];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic take_b(output logic [1:0] resp);
    int n = 0;
    resp = 'x;
    bus.axi_bready = 1'b1;
    while (!bus.axi_bvalid) begin
      @(negedge aclk);
      if (++n > 50) begin timeout("bvalid"); bus.axi_bready = 1'b0; return; end
    end
    resp = bus.axi_bresp;
    @(negedge aclk);
    bus.axi_bready = 1'b0;
  endtask

  task automatic take_r(output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    data = 'x;
    resp = 'x;
    bus.axi_rready = 1'b1;
    while (!bus.axi_rvalid) begin
      @(negedge aclk);
      if (++n > 50) begin timeout("rvalid"); bus.axi_rready = 1'b0; return; end
    end
    data = bus.axi_rdata;
    resp = bus.axi_rresp;
    @(negedge aclk);
    bus.axi_rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    resp = 'x;
    @(negedge aclk);
    bus.axi_awaddr = a; bus.axi_awvalid = 1'b1;
    bus.axi_wdata = d; bus.axi_wstrb = s; bus.axi_wvalid = 1'b1;
    while (!(aw_done && w_done)) begin
      aw_hs = bus.axi_awvalid && bus.axi_awready;
      w_hs  = bus.axi_wvalid && bus.axi_wready;
      @(negedge aclk);
      if (aw_hs) begin bus.axi_awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin bus.axi_wvalid = 1'b0;  w_done = 1;  end
      if (++n > 50) begin
        timeout("write address/data");
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        return;
      end
    end
    take_b(resp);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    data = 'x;
    resp = 'x;
    @(negedge aclk);
    bus.axi_araddr = a; bus.axi_arvalid = 1'b1;
    while (!bus.axi_arready) begin
      @(negedge aclk);
      if (++n > 50) begin timeout("read address"); bus.axi_arvalid = 1'b0; return; end
    end
    @(negedge aclk);
    bus.axi_arvalid = 1'b0;
    take_r(data, resp);
  endtask

  // Returns {bvalid, rvalid} at the first negedge where either is high.
  task automatic wait_resp(output logic [1:0] vr);
    int n = 0;
    vr = 2'b00;
    while (!(bus.axi_bvalid || bus.axi_rvalid)) begin
      @(negedge aclk);
      if (++n > 20) begin timeout("any response"); return; end
    end
    vr = {bus.axi_bvalid, bus.axi_rvalid};
  endtask

  task automatic all_outputs_zero(input string name);
    check({name, " valids/readies"},
          {bus.axi_awready, bus.axi_wready, bus.axi_arready, bus.axi_bvalid, bus.axi_rvalid}, 0);
    check({name, " resps"}, {bus.axi_bresp, bus.axi_rresp}, 0);
    check({name, " rdata"}, bus.axi_rdata, 0);
  endtask

  // Reference: index = byte address / bytes-per-beat; past DEPTH is an error slot.
  function automatic bit in_range(input logic [31:0] a);
    return (a / (DATA_W / 8)) < DEPTH;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp, vr;
    logic [31:0] d;
    int          lat, pulses;

    bus.axi_awaddr = '0; bus.axi_awvalid = 1'b0;
    bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wvalid = 1'b0;
    bus.axi_bready = 1'b0;
    bus.axi_araddr = '0; bus.axi_arvalid = 1'b0;
    bus.axi_rready = 1'b0;

    // ---- reset state, with all valids/readies from the master side asserted ----
    @(negedge aclk);
    bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1; bus.axi_arvalid = 1'b1;
    bus.axi_bready = 1'b1; bus.axi_rready = 1'b1;
    @(negedge aclk);
    all_outputs_zero("in reset");
    bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
    bus.axi_bready = 1'b0; bus.axi_rready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("readies after reset release",
          {bus.axi_awready, bus.axi_wready, bus.axi_arready}, 3'b111);

    // ---- directed vector table ----
    vt[0]  = '{1, 32'h0000_0010, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
    vt[1]  = '{0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'h1122_3344};
    vt[2]  = '{1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
    vt[3]  = '{0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD};
    vt[4]  = '{1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
    vt[5]  = '{1, 32'h0000_0800, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0};
    vt[6]  = '{0, 32'h0000_0800, 32'h0,         4'h0, 2'b10, 32'h0};
    vt[7]  = '{0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
    vt[8]  = '{1, 32'h0000_0014, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
    vt[9]  = '{1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
    vt[10] = '{0, 32'h0000_0017, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
    vt[11] = '{0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};
    vt[12] = '{1, 32'h0000_07FC, 32'h0BAD_C0DE, 4'hF, 2'b00, 32'h0};
    vt[13] = '{0, 32'h0000_07FC, 32'h0,         4'h0, 2'b00, 32'h0BAD_C0DE};
    for (int i = 0; i < 14; i++) begin
      if (vt[i].is_wr) begin
        do_write(vt[i].addr, vt[i].data, vt[i].strb, resp);
        check($sformatf("vec%0d bresp", i), resp, vt[i].resp);
      end else begin
        do_read(vt[i].addr, d, resp);
        check($sformatf("vec%0d rresp", i), resp, vt[i].resp);
        check($sformatf("vec%0d rdata", i), d, vt[i].rdata);
      end
    end

    // ---- read latency and rready stall ----
    @(negedge aclk);
    bus.axi_araddr = 32'h10; bus.axi_arvalid = 1'b1;
    check("arready idle", bus.axi_arready, 1);
    @(negedge aclk);
    bus.axi_arvalid = 1'b0;
    // handshake edge, grant cycle, then two edges -> rvalid seen at 3rd negedge
    lat = 1;
    while (!bus.axi_rvalid && lat < 20) begin @(negedge aclk); lat++; end
    check("read latency", lat, 3);
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      check("rvalid held", bus.axi_rvalid, 1);
      check("rdata held", bus.axi_rdata, 32'h11BB_33DD);
      check("rresp held", bus.axi_rresp, 2'b00);
      check("no ready in RD_RESP", {bus.axi_awready, bus.axi_wready, bus.axi_arready}, 0);
    end
    bus.axi_rready = 1'b1;
    @(negedge aclk);
    bus.axi_rready = 1'b0;
    check("rvalid after handshake", bus.axi_rvalid, 0);

    // ---- W three cycles before AW, then bready stall ----
    @(negedge aclk);
    bus.axi_wdata = 32'h5A5A_5A5A; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      pulses += int'(bus.axi_wready);
      @(negedge aclk);
      bus.axi_wvalid = 1'b0;
    end
    pulses += int'(bus.axi_wready);
    check("wready pulses", pulses, 1);
    bus.axi_awaddr = 32'h20; bus.axi_awvalid = 1'b1;
    check("awready with W held", bus.axi_awready, 1);
    @(negedge aclk);
    bus.axi_awvalid = 1'b0;
    check("bvalid in grant cycle", bus.axi_bvalid, 0);
    @(negedge aclk);
    check("bvalid one edge after grant", bus.axi_bvalid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      check("bvalid held", bus.axi_bvalid, 1);
      check("bresp held", bus.axi_bresp, 2'b00);
      check("no ready in WR_RESP", {bus.axi_awready, bus.axi_wready, bus.axi_arready}, 0);
    end
    take_b(resp);
    check("late-AW bresp", resp, 2'b00);
    do_read(32'h20, d, resp);
    check("late-AW readback", d, 32'h5A5A_5A5A);

    // ---- arbitration: write first after reset, read first on the next tie ----
    @(negedge aclk); aresetn = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    bus.axi_awaddr = 32'h30; bus.axi_awvalid = 1'b1;
    bus.axi_wdata = 32'h0102_0304; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
    bus.axi_araddr = 32'h20; bus.axi_arvalid = 1'b1;
    @(negedge aclk);
    bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
    wait_resp(vr);
    check("tie after reset: write first", vr, 2'b10);
    take_b(resp);
    check("tie1 bresp", resp, 2'b00);
    take_r(d, resp);
    check("tie1 rdata", d, 32'h5A5A_5A5A);
    do_write(32'h34, 32'h0, 4'hF, resp);
    check("plain write bresp", resp, 2'b00);
    @(negedge aclk);
    bus.axi_awaddr = 32'h38; bus.axi_awvalid = 1'b1;
    bus.axi_wdata = 32'h7777_7777; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
    bus.axi_araddr = 32'h30; bus.axi_arvalid = 1'b1;
    @(negedge aclk);
    bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
    wait_resp(vr);
    check("tie after write: read first", vr, 2'b01);
    take_r(d, resp);
    check("tie2 rdata", d, 32'h0102_0304);
    take_b(resp);
    check("tie2 bresp", resp, 2'b00);

    // ---- reset pulse while a read response is pending ----
    @(negedge aclk);
    bus.axi_araddr = 32'h30; bus.axi_arvalid = 1'b1;
    @(negedge aclk);
    bus.axi_arvalid = 1'b0;
    wait_resp(vr);
    check("rvalid before reset pulse", vr, 2'b01);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    all_outputs_zero("reset in RD_RESP");
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rvalid dropped after reset", bus.axi_rvalid, 0);
    check("arready after reset", bus.axi_arready, 1);

    // ---- randomized traffic against a word-level model ----
    for (int w = 0; w < NREG; w++) begin
      ref_mem[w] = $urandom;
      do_write(32'(w * 4), ref_mem[w], 4'hF, resp);
      check("model init bresp", resp, 2'b00);
    end
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a, wd, idx;
      logic [3:0]  s;
      if ($urandom_range(0, 7) == 0) a = 32'(DEPTH * 4) + $urandom_range(0, 32'h7FFF_0000);
      else                           a = ($urandom_range(0, NREG - 1) << 2) | $urandom_range(0, 3);
      idx = a / (DATA_W / 8);
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        s  = 4'($urandom_range(0, 15));
        do_write(a, wd, s, resp);
        check($sformatf("rand%0d bresp @%0h", t, a), resp, in_range(a) ? 2'b00 : 2'b10);
        if (in_range(a)) begin
          for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
          end
        end
      end else begin
        do_read(a, d, resp);
        check($sformatf("rand%0d rresp @%0h", t, a), resp, in_range(a) ? 2'b00 : 2'b10);
        check($sformatf("rand%0d rdata @%0h", t, a), d, in_range(a) ? ref_mem[idx] : 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
